dcache_line_wb: RTL and testbench
=================================

// Module: dcache_line_wb
// PURPOSE
//   Parametrised write-back data-cache line: one tag, LINEWORDS data words, valid/dirty, TTL age.
//   Serves CPU read/write hits with byte enables. Fills from memory in bursts; flushes dirty data before refill.
//   Instantiated N times under the dcache controller, which picks the victim by lowest ttl and drives fill_req.
// PARAMETERS
//   ADDRBITS   32   byte-address width
//   DATABITS   32   word width, multiple of 8
//   LINEWORDS  32   words per line, power of 2, >=2
//   TTLBITS    8    age counter width; MAXTTL = 2**TTLBITS-1
// PORTS
//   clk          in   1           clock, rising edge
//   reset        in   1           async, active-high
//   cpu_addr     in   ADDRBITS    byte address; low log2(DATABITS/8) bits ignored
//   cpu_rdreq    in   1           read request, single-cycle pulse
//   cpu_wrreq    in   1           write request, single-cycle pulse
//   cpu_wrdata   in   DATABITS    write data
//   cpu_byteen   in   DATABITS/8  write byte enables
//   cpu_rddata   out  DATABITS    read data, valid while cpu_valid=1
//   cpu_valid    out  1           read-hit data strobe
//   hit          out  1           registered: previous-cycle request hit
//   miss         out  1           registered: previous-cycle request missed
//   busy         out  1           line in FILL or FLUSH
//   dirty        out  1           line modified since fill
//   ttl          out  TTLBITS     age; 0 = oldest/invalid
//   ttl_tick     in   1           ageing strobe
//   fill_req     in   1           load line containing cpu_addr
//   mem_addr     out  ADDRBITS    burst/word byte address
//   mem_rdreq    out  1           one-cycle burst read request
//   mem_burstlen in   16          words per memory burst; 0 treated as 1
//   mem_rddata   in   DATABITS    fill data
//   mem_rdvalid  in   1           fill data strobe
//   mem_wrreq    out  1           flush write request, held until mem_wrack
//   mem_wrdata   out  DATABITS    flush data
//   mem_wrack    in   1           flush word accepted
// BEHAVIOUR
//   Reset: state INVALID, ttl=0, dirty=0, all outputs 0, tag=0, counters 0. Reset mid-FILL/FLUSH discards line.
//   States: INVALID, FILL, VALID, FLUSH. Tag = cpu_addr bits above line offset; match only in VALID.
//   INVALID: rd/wrreq -> miss=1 next cycle. fill_req -> latch tag, FILL.
//   VALID: read hit -> cpu_rddata/cpu_valid/hit 1 cycle later, ttl<=MAXTTL. Write hit -> enabled bytes
//     written, dirty<=1, ttl<=MAXTTL, hit=1 next cycle. Tag mismatch -> miss=1. rd+wr same cycle: write wins, no cpu_valid.
//     fill_req & dirty -> FLUSH (old tag kept); fill_req & !dirty -> latch new tag, FILL. fill_req beats CPU request.
//   FILL: mem_rdreq pulses 1 cycle at entry and after each completed burst; mem_addr = {tag, word_cnt, 0}.
//     Each mem_rdvalid writes word_cnt, increments it. Rdvalid beyond LINEWORDS or while not in FILL ignored.
//     After word LINEWORDS-1: VALID, ttl<=MAXTTL, dirty<=0 (next cycle). Min latency LINEWORDS+1 cycles.
//   FLUSH: mem_wrreq=1, mem_addr={old tag, word_cnt, 0}, mem_wrdata=word[word_cnt]; stable until mem_wrack.
//     Each ack advances; after last ack: dirty<=0, latch new tag from cpu_addr captured at fill_req, FILL.
//   busy=1 in FILL/FLUSH; CPU requests then give hit=0, miss=0 (controller must retry); fill_req ignored.
//   ttl: ttl_tick in VALID with no hit that cycle -> ttl-1, saturates at 0; hit reload wins over tick.
//   word_cnt width log2(LINEWORDS), wraps to 0 on state exit; burst counter 16 bit, compares with max(mem_burstlen,1).
// TESTING
//   Reset, rdreq @0x100 -> miss=1 next cycle, hit=0, ttl=0, busy=0.
//   fill_req @0x1000, burstlen=8, LINEWORDS=32 -> 4 mem_rdreq pulses at 0x1000/0x1020/0x1040/0x1060; VALID, ttl=255.
//   Write 0xAABBCCDD byteen=4'b0101 @0x1004 over 0x11223344 -> read returns 0x11BB33DD, dirty=1.
//   fill_req @0x2000 while dirty -> 32 writes at 0x1000..0x107C, ack every 3rd cycle respected, then fill 0x2000.
//   256 ttl_tick with no hits -> ttl saturates at 0; a hit in same cycle as tick -> ttl=255.
//   reset asserted mid-FILL (word 5) -> INVALID, mem_rdreq=0, later rdvalid ignored, miss on next rdreq.

Source files
------------

// File: rtl/dcache_line_wb.sv
// One write-back data-cache line: tag, LINEWORDS words, valid/dirty and TTL age.
// Serves CPU hits with byte enables, bursts fills in from memory and flushes dirty data first.
module dcache_line_wb #(
  parameter int ADDRBITS  = 32,
  parameter int DATABITS  = 32,
  parameter int LINEWORDS = 32,
  parameter int TTLBITS   = 8
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDRBITS-1:0]   cpu_addr,
  input  logic                  cpu_rdreq,
  input  logic                  cpu_wrreq,
  input  logic [DATABITS-1:0]   cpu_wrdata,
  input  logic [DATABITS/8-1:0] cpu_byteen,
  output logic [DATABITS-1:0]   cpu_rddata,
  output logic                  cpu_valid,
  output logic                  hit,
  output logic                  miss,
  output logic                  busy,
  output logic                  dirty,
  output logic [TTLBITS-1:0]    ttl,
  input  logic                  ttl_tick,
  input  logic                  fill_req,
  output logic [ADDRBITS-1:0]   mem_addr,
  output logic                  mem_rdreq,
  input  logic [15:0]           mem_burstlen,
  input  logic [DATABITS-1:0]   mem_rddata,
  input  logic                  mem_rdvalid,
  output logic                  mem_wrreq,
  output logic [DATABITS-1:0]   mem_wrdata,
  input  logic                  mem_wrack
);
  localparam int NBYTES = DATABITS / 8;
  localparam int OFFB   = $clog2(NBYTES);
  localparam int WB     = $clog2(LINEWORDS);
  localparam int TAGB   = ADDRBITS - WB - OFFB;
  localparam logic [TTLBITS-1:0] MAXTTL = '1;

  localparam logic [1:0] S_INVALID = 2'd0;
  localparam logic [1:0] S_FILL    = 2'd1;
  localparam logic [1:0] S_VALID   = 2'd2;
  localparam logic [1:0] S_FLUSH   = 2'd3;

  logic [1:0]          state;
  logic [TAGB-1:0]     tag, next_tag;
  logic [WB-1:0]       word_cnt;
  logic [15:0]         burst_cnt;
  logic [DATABITS-1:0] line [LINEWORDS];

  logic [TAGB-1:0] cpu_tag;
  logic [WB-1:0]   widx;
  logic [15:0]     blen;
  logic            cpu_req, tag_hit, req_hit, fill_wr, last_word, burst_done;

  assign cpu_tag    = cpu_addr[ADDRBITS-1 -: TAGB];
  assign widx       = cpu_addr[OFFB +: WB];
  assign blen       = (mem_burstlen == 16'd0) ? 16'd1 : mem_burstlen;
  assign cpu_req    = cpu_rdreq | cpu_wrreq;
  assign tag_hit    = (state == S_VALID) && (cpu_tag == tag);
  assign req_hit    = tag_hit && cpu_req && !fill_req;
  assign fill_wr    = (state == S_FILL) && mem_rdvalid;
  assign last_word  = &word_cnt;
  assign burst_done = (burst_cnt + 16'd1) >= blen;

  assign busy       = (state == S_FILL) || (state == S_FLUSH);
  assign mem_wrreq  = (state == S_FLUSH);
  assign mem_wrdata = mem_wrreq ? line[word_cnt] : '0;
  // During FLUSH tag still holds the old line; it is replaced only when the flush ends.
  assign mem_addr   = busy ? (ADDRBITS'({tag, word_cnt}) << OFFB) : '0;

  generate
    if (OFFB > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^cpu_addr[OFFB-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (fill_wr)
      line[word_cnt] <= mem_rddata;
    else if (req_hit && cpu_wrreq)
      for (int b = 0; b < NBYTES; b++)
        if (cpu_byteen[b]) line[widx][8*b +: 8] <= cpu_wrdata[8*b +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_INVALID;
      tag        <= '0;
      next_tag   <= '0;
      word_cnt   <= '0;
      burst_cnt  <= '0;
      dirty      <= 1'b0;
      ttl        <= '0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      cpu_valid  <= 1'b0;
      cpu_rddata <= '0;
      mem_rdreq  <= 1'b0;
    end else begin
      hit       <= 1'b0;
      miss      <= 1'b0;
      cpu_valid <= 1'b0;
      mem_rdreq <= 1'b0;
      case (state)
        S_INVALID: begin
          if (cpu_req) miss <= 1'b1;
          if (fill_req) begin
            tag       <= cpu_tag;
            state     <= S_FILL;
            mem_rdreq <= 1'b1;
            word_cnt  <= '0;
            burst_cnt <= '0;
          end
        end
        S_VALID: begin
          if (ttl_tick && ttl != '0) ttl <= ttl - TTLBITS'(1);
          if (fill_req) begin
            word_cnt  <= '0;
            burst_cnt <= '0;
            if (dirty) begin
              next_tag <= cpu_tag;
              state    <= S_FLUSH;
            end else begin
              tag       <= cpu_tag;
              state     <= S_FILL;
              mem_rdreq <= 1'b1;
              ttl       <= '0;
            end
          end else if (cpu_req) begin
            if (tag_hit) begin
              hit <= 1'b1;
              ttl <= MAXTTL;
              if (cpu_wrreq) dirty <= 1'b1;
              else begin
                cpu_valid  <= 1'b1;
                cpu_rddata <= line[widx];
              end
            end else begin
              miss <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (mem_rdvalid) begin
            word_cnt <= word_cnt + WB'(1);
            if (last_word) begin
              state     <= S_VALID;
              ttl       <= MAXTTL;
              dirty     <= 1'b0;
              burst_cnt <= '0;
            end else if (burst_done) begin
              burst_cnt <= '0;
              mem_rdreq <= 1'b1;
            end else begin
              burst_cnt <= burst_cnt + 16'd1;
            end
          end
        end
        default: begin
          if (mem_wrack) begin
            word_cnt <= word_cnt + WB'(1);
            if (last_word) begin
              dirty     <= 1'b0;
              tag       <= next_tag;
              state     <= S_FILL;
              mem_rdreq <= 1'b1;
              burst_cnt <= '0;
              ttl       <= '0;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_line_wb.sv
// Directed plus randomized bench for dcache_line_wb against a line-level reference model
// and a sparse backing-memory model.
module tb_dcache_line_wb;
  localparam int LW = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cpu_addr = '0;
  logic        cpu_rdreq = 1'b0, cpu_wrreq = 1'b0;
  logic [31:0] cpu_wrdata = '0;
  logic [3:0]  cpu_byteen = '0;
  logic [31:0] cpu_rddata;
  logic        cpu_valid, hit, miss, busy, dirty;
  logic [7:0]  ttl;
  logic        ttl_tick = 1'b0, fill_req = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_rdreq;
  logic [15:0] mem_burstlen = 16'd8;
  logic [31:0] mem_rddata = '0;
  logic        mem_rdvalid = 1'b0;
  logic        mem_wrreq;
  logic [31:0] mem_wrdata;
  logic        mem_wrack = 1'b0;

  always #5 clk = ~clk;

  dcache_line_wb dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_rdreq(cpu_rdreq), .cpu_wrreq(cpu_wrreq),
    .cpu_wrdata(cpu_wrdata), .cpu_byteen(cpu_byteen), .cpu_rddata(cpu_rddata), .cpu_valid(cpu_valid),
    .hit(hit), .miss(miss), .busy(busy), .dirty(dirty), .ttl(ttl), .ttl_tick(ttl_tick),
    .fill_req(fill_req), .mem_addr(mem_addr), .mem_rdreq(mem_rdreq), .mem_burstlen(mem_burstlen),
    .mem_rddata(mem_rddata), .mem_rdvalid(mem_rdvalid), .mem_wrreq(mem_wrreq),
    .mem_wrdata(mem_wrdata), .mem_wrack(mem_wrack)
  );

  int passed = 0, total = 0, failed = 0;

  // backing memory: flushed words override a fixed hash pattern
  logic [31:0] ram [logic [31:0]];
  // line reference model
  bit          r_valid = 0, r_dirty = 0;
  logic [24:0] r_tag = '0;
  logic [31:0] r_data [LW];
  int          r_ttl = 0;

  function automatic logic [31:0] ram_rd(logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return (a * 32'h9E3779B1) ^ 32'h5BD1E995;
  endfunction

  task automatic check(string t, logic [63:0] o, logic [63:0] e);
    total++;
    assert (o === e) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", t, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cpu_op(bit rd, bit wr, bit tk, logic [31:0] a, logic [31:0] d, logic [3:0] be);
    bit h;
    int i;
    logic [31:0] exp_rd;
    h = r_valid && (a[31:7] == r_tag) && (rd || wr);
    i = int'(a[6:2]);
    exp_rd = r_data[i];
    cpu_addr = a; cpu_rdreq = rd; cpu_wrreq = wr; cpu_wrdata = d; cpu_byteen = be; ttl_tick = tk;
    step();
    cpu_rdreq = 0; cpu_wrreq = 0; ttl_tick = 0;
    if (h && wr) begin
      for (int b = 0; b < 4; b++) if (be[b]) r_data[i][8*b +: 8] = d[8*b +: 8];
      r_dirty = 1;
    end
    if (h) r_ttl = 255;
    else if (tk && r_valid && r_ttl > 0) r_ttl--;
    check("hit", hit, h);
    check("miss", miss, (rd || wr) && !h);
    check("cpu_valid", cpu_valid, rd && !wr && h);
    if (rd && !wr && h) check("rddata", cpu_rddata, exp_rd);
    check("ttl", ttl, r_ttl);
    check("dirty", dirty, r_dirty);
    check("busy", busy, 0);
  endtask

  task automatic fill(logic [31:0] a, logic [15:0] bl);
    int eff, w, k, g, pulses;
    logic [24:0] nt;
    eff = (bl == 0) ? 1 : int'(bl);
    nt = a[31:7];
    mem_burstlen = bl;
    cpu_addr = a; fill_req = 1;
    step();
    fill_req = 0;
    cpu_addr = a ^ 32'h0001_0000;
    if (r_dirty) begin
      k = 0; g = 0;
      while (k < LW && g < 400) begin
        g++;
        check("flush_wrreq", mem_wrreq, 1);
        check("flush_addr", mem_addr, {r_tag, 5'(k), 2'b00});
        check("flush_data", mem_wrdata, r_data[k]);
        mem_wrack = (g % 3 == 0);
        step();
        if (mem_wrack) begin
          ram[{r_tag, 5'(k), 2'b00}] = r_data[k];
          k++;
        end
        mem_wrack = 0;
      end
      check("flush_count", k, LW);
    end
    w = 0; g = 0; pulses = 0;
    while (w < LW && g < 2000) begin
      g++;
      check("fill_busy", busy, 1);
      if (mem_rdreq) begin
        check("rdreq_addr", mem_addr, {nt, 5'(w), 2'b00});
        check("rdreq_boundary", w % eff, 0);
        pulses++;
      end
      if (g == 1) cpu_rdreq = 1;
      mem_rdvalid = (pulses * eff > w) && ($urandom_range(3) != 0);
      mem_rddata = ram_rd({nt, 5'(w), 2'b00});
      step();
      if (g == 1) begin
        check("busy_hit", hit, 0);
        check("busy_miss", miss, 0);
        cpu_rdreq = 0;
      end
      if (mem_rdvalid) begin
        r_data[w] = mem_rddata;
        w++;
      end
      mem_rdvalid = 0;
    end
    check("fill_words", w, LW);
    check("fill_pulses", pulses, (LW + eff - 1) / eff);
    r_valid = 1; r_dirty = 0; r_ttl = 255; r_tag = nt;
    check("fill_done_busy", busy, 0);
    check("fill_done_ttl", ttl, 255);
    check("fill_done_dirty", dirty, 0);
    check("fill_done_rdreq", mem_rdreq, 0);
  endtask

  initial begin
    logic [31:0] bases [4];
    logic [15:0] bls [6];
    logic [31:0] a;
    int w;
    bases = '{32'h1000, 32'h2000, 32'h3000, 32'hABC80};
    bls   = '{16'd0, 16'd1, 16'd3, 16'd8, 16'd32, 16'd40};

    step(); step();
    reset = 0;
    step();
    check("rst_hit", hit, 0);
    check("rst_miss", miss, 0);
    check("rst_cpu_valid", cpu_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_dirty", dirty, 0);
    check("rst_ttl", ttl, 0);
    check("rst_mem_rdreq", mem_rdreq, 0);
    check("rst_mem_wrreq", mem_wrreq, 0);
    check("rst_mem_addr", mem_addr, 0);

    cpu_op(1, 0, 0, 32'h100, 0, 0);

    ram[32'h1004] = 32'h11223344;
    fill(32'h1000, 16'd8);
    cpu_op(0, 1, 0, 32'h1004, 32'hAABBCCDD, 4'b0101);
    cpu_op(1, 0, 0, 32'h1004, 0, 0);
    check("byteen_merge", cpu_rddata, 32'h11BB33DD);
    check("dirty_after_write", dirty, 1);

    fill(32'h2000, 16'd8);
    check("flushed_word", ram_rd(32'h1004), 32'h11BB33DD);

    for (int i = 0; i < 256; i++) cpu_op(0, 0, 1, 32'h2000, 0, 0);
    check("ttl_saturated", ttl, 0);
    cpu_op(1, 0, 1, 32'h2004, 0, 0);
    check("ttl_hit_beats_tick", ttl, 255);

    for (int i = 0; i < 400; i++) begin
      a = bases[$urandom_range(3)] | ($urandom_range(31) << 2);
      if ($urandom_range(19) == 0) fill(a, bls[$urandom_range(5)]);
      else cpu_op($urandom_range(1) == 1, $urandom_range(2) == 0, $urandom_range(1) == 1,
                  a, $urandom, 4'($urandom_range(15)));
    end

    // reset mid-fill: discard the line, ignore stray fill data afterwards
    mem_burstlen = 16'd32;
    cpu_addr = 32'h4000; fill_req = 1;
    step();
    fill_req = 0;
    w = 0;
    while (w < 5) begin
      mem_rdvalid = 1; mem_rddata = $urandom;
      step();
      w++;
    end
    reset = 1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_rdreq", mem_rdreq, 0);
    check("midrst_ttl", ttl, 0);
    step();
    reset = 0;
    r_valid = 0; r_dirty = 0; r_ttl = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      check("stray_rdvalid_busy", busy, 0);
      check("stray_rdvalid_rdreq", mem_rdreq, 0);
    end
    mem_rdvalid = 0;
    cpu_op(1, 0, 0, 32'h4000, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
